shift_sequencer: RTL

//   Sequences the 32-bit Shifter for register-specified shifts (8-bit amount, 0..255).

---
 rtl/shift_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-pass sequencer for the 32-bit Shifter: splits register-specified shift amounts
// into passes of at most PASS_MAX and returns the final shifted value and carry-out.
//   state | meaning
//   IDLE  | waiting for Start; outputs hold the last result
//   SHIFT | one Shifter pass per cycle while rem > 0
//   DONE  | ShOut/ShCarry valid, Done pulses, back to IDLE
module shift_sequencer #(
    parameter int PASS_MAX = 31,
    parameter int AMT_W    = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       ShType,
    input  logic [AMT_W-1:0] Amt,
    input  logic [31:0]      Operand,
    input  logic             CarryIn,
    output logic             Busy,
    output logic             Done,
    output logic [31:0]      ShOut,
    output logic             ShCarry,
    output logic [1:0]       ShCtl,
    output logic [4:0]       Shamt5Ctl,
    output logic [31:0]      ShInCtl,
    input  logic [31:0]      ShOutRet
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

    localparam logic [1:0]       SH_LSL    = 2'b00;
    localparam logic [1:0]       SH_ROR    = 2'b11;
    localparam logic [AMT_W-1:0] AMT_CLAMP = AMT_W'(33);
    localparam logic [4:0]       PASS_LIM  = 5'(PASS_MAX);

    stateT            state, nextState;
    logic [1:0]       shType;
    logic [5:0]       rem, remNext, startRem;
    logic [4:0]       passAmt, lslIdx, rshIdx;
    logic             carry, startCarry, shiftCarry;
    logic [AMT_W-1:0] amtClamped;

    // Clamping non-rotate amounts to 33 makes the >=32 cases fall out of normal passes.
    always_comb begin
        amtClamped = (Amt > AMT_CLAMP) ? AMT_CLAMP : Amt;
        startRem   = (ShType == SH_ROR) ? {1'b0, Amt[4:0]} : 6'(amtClamped);
        startCarry = (ShType == SH_ROR && Amt != '0 && Amt[4:0] == 5'd0) ? Operand[31] : CarryIn;
        passAmt    = (rem > {1'b0, PASS_LIM}) ? PASS_LIM : rem[4:0];
        remNext    = rem - {1'b0, passAmt};
        lslIdx     = 5'(6'd32 - {1'b0, passAmt});
        rshIdx     = passAmt - 5'd1;
        case (shType)
            SH_LSL:  shiftCarry = ShInCtl[lslIdx];
            SH_ROR:  shiftCarry = ShOutRet[31];
            default: shiftCarry = ShInCtl[rshIdx];
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        Busy      = (state != IDLE);
        Done      = 1'b0;
        ShCtl     = 2'b00;
        Shamt5Ctl = 5'd0;
        case (state)
            IDLE: begin
                if (Start) begin
                    nextState = (startRem != 6'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                ShCtl     = shType;
                Shamt5Ctl = passAmt;
                if (remNext == 6'd0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // The result registers load on entry to DONE so they are already valid in the Done cycle.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            shType  <= 2'b00;
            rem     <= 6'd0;
            carry   <= 1'b0;
            ShInCtl <= 32'd0;
            ShOut   <= 32'd0;
            ShCarry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        shType  <= ShType;
                        rem     <= startRem;
                        carry   <= startCarry;
                        ShInCtl <= Operand;
                        if (startRem == 6'd0) begin
                            ShOut   <= Operand;
                            ShCarry <= startCarry;
                        end
                    end
                end
                SHIFT: begin
                    rem     <= remNext;
                    carry   <= shiftCarry;
                    ShInCtl <= ShOutRet;
                    if (remNext == 6'd0) begin
                        ShOut   <= ShOutRet;
                        ShCarry <= shiftCarry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
